// File: rtl/fir_pkg.sv
// Shared constants for the FIR datapath: default sample widths and
// requantisation shift used by the serial FIR and its output stage.
package fir_pkg;

  localparam int unsigned FIR_IN_W  = 29;
  localparam int unsigned FIR_OUT_W = 12;
  localparam int unsigned FIR_SHIFT = 17;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word fall-through FIFO. Pointers carry one extra wrap
// bit so full and empty are distinguishable without an occupancy counter.
// The storage array is intentionally not reset.
module sync_fifo #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PTR_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // Status decode and transfer qualification; a write into a full FIFO is
  // allowed only when a read frees an entry on the same edge.
  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    do_rd   = rd_en && !empty;
    do_wr   = wr_en && (!full || do_rd);
    rd_data = mem[rd_ptr[AW-1:0]];
  end

  // Pointer registers, wrapping modulo 2*DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Data storage, written without reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/fir_requant_fifo.sv
// FIR output requantiser: round-half-up by SHIFT bits, saturate to OUT_W,
// and buffer results in a small FWFT FIFO with overflow/saturation flags.
module fir_requant_fifo
  import fir_pkg::*;
#(
  parameter int unsigned IN_W  = FIR_IN_W,
  parameter int unsigned OUT_W = FIR_OUT_W,
  parameter int unsigned SHIFT = FIR_SHIFT,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [IN_W-1:0]  yin,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [OUT_W-1:0] dout,
  output logic             ovf,
  output logic [7:0]       sat_cnt,
  input  logic             flag_clr
);

  localparam int unsigned SUM_W = IN_W + 1;

  localparam logic signed [SUM_W-1:0] ROUND_K = {{(SUM_W-1){1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [SUM_W-1:0] Q_MAX   = {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] Q_MIN   = {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic                    s1_vld;
  logic signed [SUM_W-1:0] s1_sum;
  logic signed [SUM_W-1:0] q_full;
  logic                    clip;
  logic [OUT_W-1:0]        q_sat;

  logic                    fifo_full;
  logic                    fifo_empty;
  logic [OUT_W-1:0]        fifo_rd_data;
  logic                    pop;
  logic                    drop;

  // Stage 1 valid flag (control, reset).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) s1_vld <= 1'b0;
    else     s1_vld <= valid_in;
  end

  // Stage 1 data: sign-extended sample plus half an output LSB.
  always_ff @(posedge clk) begin
    if (valid_in) s1_sum <= {yin[IN_W-1], yin} + ROUND_K;
  end

  // Stage 2: arithmetic shift and clip; the FIFO write is the stage register.
  always_comb begin
    q_full = s1_sum >>> SHIFT;
    clip   = 1'b0;
    q_sat  = q_full[OUT_W-1:0];
    if (q_full > Q_MAX) begin
      clip  = 1'b1;
      q_sat = Q_MAX[OUT_W-1:0];
    end else if (q_full < Q_MIN) begin
      clip  = 1'b1;
      q_sat = Q_MIN[OUT_W-1:0];
    end
  end

  sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (s1_vld),
    .wr_data (q_sat),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Handshake and output view; dout is forced to zero while nothing is held
  // so the unreset storage never leaks out.
  always_comb begin
    pop        = dout_ready && !fifo_empty;
    drop       = s1_vld && fifo_full && !pop;
    dout_valid = !fifo_empty;
    dout       = fifo_empty ? '0 : fifo_rd_data;
  end

  // Sticky overflow and saturating clip counter; a clear beats a new event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf     <= 1'b0;
      sat_cnt <= '0;
    end else if (flag_clr) begin
      ovf     <= 1'b0;
      sat_cnt <= '0;
    end else begin
      if (drop) ovf <= 1'b1;
      if (s1_vld && clip && (sat_cnt != '1)) sat_cnt <= sat_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_fir_requant_fifo.sv
// Self-checking bench for fir_requant_fifo: directed cases for rounding,
// clipping, overflow, simultaneous push/pop and reset, then random traffic,
// all checked against a queue-based reference model.
module tb_fir_requant_fifo;

  localparam int IN_W  = 29;
  localparam int OUT_W = 12;
  localparam int SHIFT = 17;
  localparam int DEPTH = 4;
  localparam int ONE   = 1 << SHIFT;

  logic             clk = 1'b0;
  logic             rst;
  logic             valid_in;
  logic [IN_W-1:0]  yin;
  logic             dout_valid;
  logic             dout_ready;
  logic [OUT_W-1:0] dout;
  logic             ovf;
  logic [7:0]       sat_cnt;
  logic             flag_clr;

  int checks = 0;
  int errors = 0;

  fir_requant_fifo #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .yin        (yin),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout       (dout),
    .ovf        (ovf),
    .sat_cnt    (sat_cnt),
    .flag_clr   (flag_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: floor((y + 2^(SHIFT-1)) / 2^SHIFT), clipped to OUT_W signed.
  function automatic int ref_requant(input logic [IN_W-1:0] y, output bit clipped);
    longint v;
    longint q;
    v = longint'($signed(y)) + (longint'(1) << (SHIFT - 1));
    q = v >>> SHIFT;
    clipped = 1'b0;
    if (q > (longint'(1) << (OUT_W - 1)) - 1) begin
      q = (longint'(1) << (OUT_W - 1)) - 1;
      clipped = 1'b1;
    end else if (q < -(longint'(1) << (OUT_W - 1))) begin
      q = -(longint'(1) << (OUT_W - 1));
      clipped = 1'b1;
    end
    return int'(q);
  endfunction

  // Reference model state: expected FIFO contents (scoreboard), one pending
  // sample in flight, and the flag values.
  int              sb[$];
  bit              p_vld;
  logic [IN_W-1:0] p_y;
  bit              m_ovf;
  int              m_sat;
  bit              m_pop;
  bit              m_clip;
  int              m_q;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sb.delete();
      p_vld = 1'b0;
      m_ovf = 1'b0;
      m_sat = 0;
    end else begin
      m_pop = dout_ready && (sb.size() != 0);
      if (m_pop) void'(sb.pop_front());
      if (p_vld) begin
        m_q = ref_requant(p_y, m_clip);
        if (m_clip && m_sat < 255) m_sat++;
        if (sb.size() < DEPTH) sb.push_back(m_q);
        else m_ovf = 1'b1;
      end
      if (flag_clr) begin
        m_ovf = 1'b0;
        m_sat = 0;
      end
      p_vld = valid_in;
      p_y   = yin;
    end
  end

  // Monitor: compares the DUT output view against the scoreboard head.
  always @(negedge clk) begin
    chk("dout_valid", int'(dout_valid), int'(sb.size() != 0));
    if (sb.size() != 0) chk("dout", int'($signed(dout)), sb[0]);
    if (rst) chk("dout_in_reset", int'(dout), 0);
    chk("ovf", int'(ovf), int'(m_ovf));
    chk("sat_cnt", int'(sat_cnt), m_sat);
  end

  task automatic cyc(input bit v, input int y, input bit rdy, input bit clr);
    valid_in   = v;
    yin        = IN_W'(y);
    dout_ready = rdy;
    flag_clr   = clr;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    flag_clr = 1'b0;
  endtask

  int r;

  initial begin
    rst        = 1'b1;
    valid_in   = 1'b0;
    yin        = '0;
    dout_ready = 1'b0;
    flag_clr   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", int'(dout_valid), 0);
    chk("reset_dout", int'(dout), 0);
    chk("reset_ovf", int'(ovf), 0);
    chk("reset_sat", int'(sat_cnt), 0);
    rst = 1'b0;
    cyc(0, 0, 1, 0);

    // Latency: output valid exactly two edges after the sampling edge.
    cyc(1, 131072, 1, 0);
    chk("lat_1edge_valid", int'(dout_valid), 0);
    cyc(0, 0, 1, 0);
    chk("lat_2edge_valid", int'(dout_valid), 1);
    chk("lat_2edge_dout", int'($signed(dout)), 1);
    cyc(0, 0, 1, 0);

    // Round-half-up boundaries, back to back.
    cyc(1, 65536, 1, 0);
    cyc(1, -65536, 1, 0);
    chk("round_pos_half", int'($signed(dout)), 1);
    cyc(1, 65535, 1, 0);
    chk("round_neg_half", int'($signed(dout)), 0);
    cyc(0, 0, 1, 0);
    chk("round_below_half", int'($signed(dout)), 0);
    cyc(0, 0, 1, 0);

    // Clipping at the positive end, exact fit at the negative end.
    cyc(1, 32'h0FFF_FFFF, 1, 0);
    cyc(0, 0, 1, 0);
    chk("clip_hi_dout", int'($signed(dout)), 2047);
    chk("clip_hi_sat", int'(sat_cnt), 1);
    cyc(1, 32'h1000_0000, 1, 0);
    cyc(0, 0, 1, 0);
    chk("min_dout", int'($signed(dout)), -2048);
    chk("min_sat", int'(sat_cnt), 1);
    cyc(0, 0, 1, 1);
    chk("clr_sat", int'(sat_cnt), 0);

    // Overflow: five samples into a stalled FIFO of four.
    for (int k = 1; k <= 5; k++) cyc(1, k * ONE, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("ovf_set", int'(ovf), 1);
    for (int k = 1; k <= 4; k++) begin
      chk("ovf_drain", int'($signed(dout)), k);
      cyc(0, 0, 1, 0);
    end
    chk("ovf_empty", int'(dout_valid), 0);

    // Full FIFO with write and pop on the same edge.
    cyc(0, 0, 0, 1);
    for (int k = 1; k <= 4; k++) cyc(1, k * ONE, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 9 * ONE, 0, 0);
    cyc(0, 0, 1, 0);
    chk("full_pw_ovf", int'(ovf), 0);
    chk("full_pw_head", int'($signed(dout)), 2);
    begin
      int order[4] = '{2, 3, 4, 9};
      for (int i = 0; i < 4; i++) begin
        chk("full_pw_drain", int'($signed(dout)), order[i]);
        cyc(0, 0, 1, 0);
      end
    end
    chk("full_pw_empty", int'(dout_valid), 0);

    // Reset with three entries held and one sample in flight.
    for (int k = 1; k <= 3; k++) cyc(1, k * ONE, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 4 * ONE, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", int'(dout_valid), 0);
    chk("midrst_dout", int'(dout), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(1, 7 * ONE, 1, 0);
    cyc(0, 0, 1, 0);
    chk("postrst_valid", int'(dout_valid), 1);
    chk("postrst_dout", int'($signed(dout)), 7);
    cyc(0, 0, 1, 0);

    // Random traffic mixing full-range and near-zero samples.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) r = int'($urandom);
      else r = int'($urandom_range(0, 1 << 21)) - (1 << 20);
      cyc(bit'($urandom_range(0, 1)), r, bit'($urandom_range(0, 2) != 0),
          bit'($urandom_range(0, 40) == 0));
    end
    repeat (DEPTH + 4) cyc(0, 0, 1, 0);
    chk("final_empty", int'(dout_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
